// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains a registered-output synchronous FIFO into an
// AXI4-Stream master. A 2-entry skid buffer absorbs the FIFO's one-cycle read
// latency so the stream sustains one beat per cycle, and tlast is generated
// every LEN beats for fixed-length packets.
module fifo_axis_reader #(
    parameter int D_W = 32,
    parameter int LEN = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_read,
    input  logic signed [D_W-1:0]  fifo_data,
    output logic signed [D_W-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [$clog2(LEN):0]   beat_cnt
);

    localparam int             BW        = $clog2(LEN) + 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(LEN - 1);

    // Buffer: head_q drives tdata, tail_q holds the second entry.
    logic signed [D_W-1:0] head_q, head_d;
    logic signed [D_W-1:0] tail_q, tail_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  rd_pend_q;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  tvalid_q, tlast_q;

    logic                  pop;
    logic [2:0]            occ;
    logic [1:0]            cnt_after_pop;

    assign pop           = tvalid_q && m_axis_tready;
    assign m_axis_tdata  = head_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign beat_cnt      = beat_q;

    // Read issue: slots already committed (held + in flight - leaving) must
    // leave room for the word this read will return next cycle.
    always_comb begin
        occ       = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        fifo_read = !rst && !fifo_empty && (occ < 3'd2);
    end

    // Buffer update: pop shifts the tail forward, then a returning word lands
    // in the first free slot after the pop.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        cnt_after_pop = buf_cnt_q - {1'b0, pop};
        if (pop) begin
            head_d = tail_q;
        end
        if (rd_pend_q) begin
            if (cnt_after_pop == 2'd0) begin
                head_d = fifo_data;
            end else begin
                tail_d = fifo_data;
            end
        end
        buf_cnt_d = cnt_after_pop + {1'b0, rd_pend_q};
    end

    // Beat counter: advances only on pop, wraps after the tlast beat.
    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
        end
    end

    // State registers; tvalid/tlast are registered alongside the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            buf_cnt_q <= 2'd0;
            rd_pend_q <= 1'b0;
            beat_q    <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            buf_cnt_q <= buf_cnt_d;
            rd_pend_q <= fifo_read;
            beat_q    <= beat_d;
            tvalid_q  <= (buf_cnt_d != 2'd0);
            tlast_q   <= (beat_d == LAST_BEAT);
        end
    end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Testbench for fifo_axis_reader: a behavioural FIFO feeds the DUT, and every
// cycle the stream is compared with the written word sequence and a pop-count
// packet model.
module tb_fifo_axis_reader;

    localparam int D_W = 32;
    localparam int LEN = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  fifo_rst = 1'b0;
    logic                  fifo_empty;
    logic                  fifo_read;
    logic signed [D_W-1:0] fifo_data;
    logic signed [D_W-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready = 1'b0;
    logic                  m_axis_tlast;
    logic [$clog2(LEN):0]  beat_cnt;

    fifo_axis_reader #(.D_W(D_W), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
        .fifo_data(fifo_data), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: word array plus write/read totals, registered read.
    logic signed [D_W-1:0] mem [0:1023];
    int wr_total = 0;
    int rd_total = 0;
    assign fifo_empty = (wr_total == rd_total);

    always @(posedge clk) begin
        if (fifo_rst) rd_total <= wr_total;
        else if (fifo_read) begin
            fifo_data <= mem[rd_total];
            rd_total  <= rd_total + 1;
        end
    end

    // Reference state: next expected word index and beat position in packet.
    int checks = 0, errors = 0;
    int out_idx = 0, beat_m = 0;
    int npop = 0, nread = 0, nlast = 0;
    logic hold_v = 1'b0, hold_l = 1'b0;
    logic signed [D_W-1:0] hold_d = '0, last_data = '0;
    logic s_pop = 1'b0;
    int s_bc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic signed [D_W-1:0] v);
        mem[wr_total] = v;
        wr_total++;
    endtask

    // One clock: check just before the edge, advance model, return at posedge+1.
    task automatic cyc();
        @(negedge clk);
        s_pop = 1'b0;
        if (!rst) begin
            chk("read_on_empty", fifo_read && fifo_empty, 0);
            chk("beat_cnt", beat_cnt, beat_m);
            if (hold_v) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, hold_d);
                chk("hold_last", m_axis_tlast, hold_l);
            end
            if (m_axis_tvalid) begin
                chk("data", m_axis_tdata, mem[out_idx]);
                chk("last", m_axis_tlast, beat_m == LEN - 1);
            end
            if (fifo_read) nread++;
            s_pop  = m_axis_tvalid && m_axis_tready;
            s_bc   = int'(beat_cnt);
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold_d = m_axis_tdata;
            hold_l = m_axis_tlast;
            if (s_pop) begin
                if (m_axis_tlast) begin
                    nlast++;
                    last_data = m_axis_tdata;
                end
                out_idx++;
                beat_m = (beat_m + 1) % LEN;
                npop++;
            end
        end else begin
            chk("rst_read", fifo_read, 0);
            beat_m = 0;
            hold_v = 1'b0;
            if (fifo_rst) out_idx = wr_total;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fifo_rst = 1'b1;
        cyc();
        rst = 1'b0; fifo_rst = 1'b0;
    endtask

    initial begin
        int base, base_l, first, lastc, k, pushed;
        logic signed [D_W-1:0] w0;

        // Reset with a non-empty FIFO: nothing read, outputs cleared.
        m_axis_tready = 1'b1;
        push(32'sd77); push(-32'sd5); push(32'sd9);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_empty_flag", fifo_empty, 0);
            chk("rst_tvalid", m_axis_tvalid, 0);
            chk("rst_tlast", m_axis_tlast, 0);
            chk("rst_beat", beat_cnt, 0);
            chk("rst_tdata", m_axis_tdata, 0);
        end
        rst = 1'b0;
        cyc();
        chk("lat_1edge_tvalid", m_axis_tvalid, 0);
        cyc();
        chk("lat_2edge_tvalid", m_axis_tvalid, 1);
        chk("lat_2edge_tdata", m_axis_tdata, 77);
        repeat (6) cyc();
        chk("rst_drain", npop, 3);

        // Streaming, LEN=4: eight back-to-back beats, tlast on 0 and 4.
        do_reset();
        for (int v = -3; v <= 4; v++) push(D_W'(v));
        base = npop; base_l = nlast; first = -1; lastc = -1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (s_pop) begin
                if (first < 0) first = i;
                lastc = i;
            end
        end
        chk("stream_beats", npop - base, 8);
        chk("stream_nogap", lastc - first, 7);
        chk("stream_nlast", nlast - base_l, 2);
        chk("stream_lastval", last_data, 4);

        // Backpressure: exactly two reads while stalled, head word held.
        do_reset();
        m_axis_tready = 1'b0;
        w0 = 32'sh7fff_fff0;
        push(w0);
        for (int i = 1; i < 6; i++) push(D_W'(-i * 1000));
        base = nread;
        repeat (10) cyc();
        chk("bp_reads", nread - base, 2);
        chk("bp_tvalid", m_axis_tvalid, 1);
        chk("bp_tdata", m_axis_tdata, w0);
        base = npop;
        m_axis_tready = 1'b1;
        repeat (12) cyc();
        chk("bp_release", npop - base, 6);

        // Random data and random ready against the scoreboard.
        do_reset();
        base = npop; base_l = nlast; pushed = 0; k = 0;
        while ((npop - base < 200) && (k < 3000)) begin
            if (pushed < 200 && ($urandom % 4) != 0) begin
                push($urandom);
                pushed++;
            end
            m_axis_tready = ($urandom % 2) == 1;
            cyc();
            k++;
        end
        chk("rand_pops", npop - base, 200);
        chk("rand_tlasts", nlast - base_l, 200 / LEN);
        m_axis_tready = 1'b1;

        // FIFO runs dry mid-packet: tvalid drops, packet boundary preserved.
        do_reset();
        base = npop; base_l = nlast;
        push(32'sd10); push(32'sd11);
        repeat (9) cyc();
        chk("uf_first_pops", npop - base, 2);
        chk("uf_tvalid_drop", m_axis_tvalid, 0);
        chk("uf_beat_hold", beat_cnt, 2);
        chk("uf_no_last_yet", nlast - base_l, 0);
        push(32'sd12); push(32'sd13);
        repeat (6) cyc();
        chk("uf_total_pops", npop - base, 4);
        chk("uf_nlast", nlast - base_l, 1);
        chk("uf_lastval", last_data, 13);

        // Reset after two beats of a packet, then a fresh packet.
        do_reset();
        for (int i = 0; i < 4; i++) push(D_W'(100 + i));
        base = npop; k = 0;
        while ((npop - base < 2) && (k < 20)) begin cyc(); k++; end
        chk("mr_pre_pops", npop - base, 2);
        rst = 1'b1; fifo_rst = 1'b1;
        cyc();
        rst = 1'b0; fifo_rst = 1'b0;
        chk("mr_beat", beat_cnt, 0);
        chk("mr_tvalid", m_axis_tvalid, 0);
        for (int i = 0; i < 4; i++) push(D_W'(200 + i));
        base = npop; base_l = nlast; first = -1; k = 0;
        while ((npop - base < 4) && (k < 20)) begin
            cyc();
            if (s_pop && first < 0) first = s_bc;
            k++;
        end
        chk("mr_post_pops", npop - base, 4);
        chk("mr_first_beat", first, 0);
        chk("mr_nlast", nlast - base_l, 1);
        chk("mr_lastval", last_data, 203);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
